// File: rtl/colorconv_pipe_if.sv
// Pixel stream bus for colorconv_pipe: raw input pixel side (in_*) and
// converted line-buffer write side.
interface colorconv_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  in_wren;
  logic [ADDR_WIDTH-1:0] in_wraddr;
  logic [7:0]            in_red;
  logic [7:0]            in_green;
  logic [7:0]            in_blue;
  logic                  in_starttrigger;

  logic                  wren;
  logic [ADDR_WIDTH-1:0] wraddr;
  logic [23:0]           wrdata;
  logic                  starttrigger;

  modport master (
    output in_wren, in_wraddr, in_red, in_green, in_blue, in_starttrigger,
    input  wren, wraddr, wrdata, starttrigger
  );

  modport slave (
    input  in_wren, in_wraddr, in_red, in_green, in_blue, in_starttrigger,
    output wren, wraddr, wrdata, starttrigger
  );
endinterface

// File: rtl/colorconv_pipe.sv
// Three-stage pixel colour-format converter feeding a line buffer.
// The conversion mode is latched on frame-start pixels and carried per stage.
module colorconv_pipe #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter bit          ENABLE_YCBCR = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] color_config,
  output logic [2:0] mode_active,
  colorconv_if.slave bus
);

  localparam int unsigned CH_W   = 8;
  localparam int unsigned PROD_W = 18;
  localparam int unsigned SUM_W  = 20;
  localparam int unsigned LIM_W  = 16;

  localparam logic [2:0] MODE_RGB888  = 3'd0;
  localparam logic [2:0] MODE_RGB555  = 3'd1;
  localparam logic [2:0] MODE_RGB565  = 3'd2;
  localparam logic [2:0] MODE_LIMITED = 3'd3;
  localparam logic [2:0] MODE_YCBCR   = 3'd4;

  function automatic logic [CH_W-1:0] expand5(input logic [CH_W-1:0] c);
    return c | (c >> 5);
  endfunction

  function automatic logic [CH_W-1:0] expand6(input logic [CH_W-1:0] c);
    return c | (c >> 6);
  endfunction

  function automatic logic signed [PROD_W-1:0] mul_coef(input logic [CH_W-1:0] c,
                                                        input logic signed [PROD_W-1:0] k);
    return $signed({10'd0, c}) * k;
  endfunction

  function automatic logic [CH_W-1:0] sat8(input logic signed [SUM_W-1:0] v);
    if (v < 20'sd0)        return 8'd0;
    else if (v > 20'sd255) return 8'hFF;
    else                   return v[CH_W-1:0];
  endfunction

  // Rounded, floored (arithmetic shift) weighted sum of three products plus offset.
  function automatic logic [CH_W-1:0] ycc_chan(input logic signed [PROD_W-1:0] p0,
                                               input logic signed [PROD_W-1:0] p1,
                                               input logic signed [PROD_W-1:0] p2,
                                               input logic signed [SUM_W-1:0]  offset);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2) + 20'sd128;
    return sat8((s >>> 8) + offset);
  endfunction

  function automatic logic [CH_W-1:0] lim_chan(input logic [LIM_W-1:0] p);
    return sat8($signed(SUM_W'((p + 16'd128) >> 8)) + 20'sd16);
  endfunction

  // ---------------------------------------------------------------- S1
  logic [2:0] mode_sel_c;

  // Mode only switches on a frame-start pixel; unsupported codes fall back to RGB888.
  always_comb begin
    mode_sel_c = mode_active;
    if (bus.in_starttrigger) begin
      case (color_config)
        MODE_RGB555, MODE_RGB565, MODE_LIMITED: mode_sel_c = color_config;
        MODE_YCBCR: mode_sel_c = ENABLE_YCBCR ? MODE_YCBCR : MODE_RGB888;
        default:    mode_sel_c = MODE_RGB888;
      endcase
    end
  end

  logic                  s1_valid;
  logic                  s1_trig;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [2:0]            s1_mode;
  logic [CH_W-1:0]       s1_r;
  logic [CH_W-1:0]       s1_g;
  logic [CH_W-1:0]       s1_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_trig     <= 1'b0;
      s1_addr     <= '0;
      s1_mode     <= MODE_RGB888;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      mode_active <= MODE_RGB888;
    end else begin
      s1_valid    <= bus.in_wren;
      s1_trig     <= bus.in_starttrigger;
      s1_addr     <= bus.in_wraddr;
      s1_mode     <= mode_sel_c;
      s1_r        <= bus.in_red;
      s1_g        <= bus.in_green;
      s1_b        <= bus.in_blue;
      mode_active <= mode_sel_c;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [23:0] direct_c;

  // Modes 0-2 finish here; bit replication fills the low bits of 5/6-bit channels.
  always_comb begin
    direct_c = {s1_r, s1_g, s1_b};
    case (s1_mode)
      MODE_RGB555: direct_c = {expand5(s1_r), expand5(s1_g), expand5(s1_b)};
      MODE_RGB565: direct_c = {expand5(s1_r), expand6(s1_g), expand5(s1_b)};
      default:     direct_c = {s1_r, s1_g, s1_b};
    endcase
  end

  logic signed [PROD_W-1:0] y_r_c, y_g_c, y_b_c;
  logic signed [PROD_W-1:0] cb_r_c, cb_g_c, cb_b_c;
  logic signed [PROD_W-1:0] cr_r_c, cr_g_c, cr_b_c;

  // BT.601 limited-range coefficient products; tied off when YCbCr is not built.
  always_comb begin
    y_r_c  = '0;
    y_g_c  = '0;
    y_b_c  = '0;
    cb_r_c = '0;
    cb_g_c = '0;
    cb_b_c = '0;
    cr_r_c = '0;
    cr_g_c = '0;
    cr_b_c = '0;
    if (ENABLE_YCBCR) begin
      y_r_c  = mul_coef(s1_r, 18'sd66);
      y_g_c  = mul_coef(s1_g, 18'sd129);
      y_b_c  = mul_coef(s1_b, 18'sd25);
      cb_r_c = mul_coef(s1_r, -18'sd38);
      cb_g_c = mul_coef(s1_g, -18'sd74);
      cb_b_c = mul_coef(s1_b, 18'sd112);
      cr_r_c = mul_coef(s1_r, 18'sd112);
      cr_g_c = mul_coef(s1_g, -18'sd94);
      cr_b_c = mul_coef(s1_b, -18'sd18);
    end
  end

  logic                     s2_valid;
  logic                     s2_trig;
  logic [ADDR_WIDTH-1:0]    s2_addr;
  logic [2:0]               s2_mode;
  logic [23:0]              s2_direct;
  logic [LIM_W-1:0]         s2_lim_r, s2_lim_g, s2_lim_b;
  logic signed [PROD_W-1:0] s2_y_r, s2_y_g, s2_y_b;
  logic signed [PROD_W-1:0] s2_cb_r, s2_cb_g, s2_cb_b;
  logic signed [PROD_W-1:0] s2_cr_r, s2_cr_g, s2_cr_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_trig   <= 1'b0;
      s2_addr   <= '0;
      s2_mode   <= MODE_RGB888;
      s2_direct <= '0;
      s2_lim_r  <= '0;
      s2_lim_g  <= '0;
      s2_lim_b  <= '0;
      s2_y_r    <= '0;
      s2_y_g    <= '0;
      s2_y_b    <= '0;
      s2_cb_r   <= '0;
      s2_cb_g   <= '0;
      s2_cb_b   <= '0;
      s2_cr_r   <= '0;
      s2_cr_g   <= '0;
      s2_cr_b   <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_trig   <= s1_trig;
      s2_addr   <= s1_addr;
      s2_mode   <= s1_mode;
      s2_direct <= direct_c;
      s2_lim_r  <= LIM_W'(s1_r) * 16'd220;
      s2_lim_g  <= LIM_W'(s1_g) * 16'd220;
      s2_lim_b  <= LIM_W'(s1_b) * 16'd220;
      s2_y_r    <= y_r_c;
      s2_y_g    <= y_g_c;
      s2_y_b    <= y_b_c;
      s2_cb_r   <= cb_r_c;
      s2_cb_g   <= cb_g_c;
      s2_cb_b   <= cb_b_c;
      s2_cr_r   <= cr_r_c;
      s2_cr_g   <= cr_g_c;
      s2_cr_b   <= cr_b_c;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [23:0] data_c;

  always_comb begin
    data_c = s2_direct;
    case (s2_mode)
      MODE_LIMITED: data_c = {lim_chan(s2_lim_r), lim_chan(s2_lim_g), lim_chan(s2_lim_b)};
      MODE_YCBCR:   data_c = {ycc_chan(s2_y_r,  s2_y_g,  s2_y_b,  20'sd16),
                              ycc_chan(s2_cb_r, s2_cb_g, s2_cb_b, 20'sd128),
                              ycc_chan(s2_cr_r, s2_cr_g, s2_cr_b, 20'sd128)};
      default:      data_c = s2_direct;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.wren         <= 1'b0;
      bus.starttrigger <= 1'b0;
      bus.wraddr       <= '0;
      bus.wrdata       <= '0;
    end else begin
      bus.wren         <= s2_valid;
      bus.starttrigger <= s2_trig;
      bus.wraddr       <= s2_addr;
      bus.wrdata       <= data_c;
    end
  end

endmodule
